// File: rtl/arm_cond_unit.sv
// arm_cond_unit: NZCV status register and ARM condition-code commit logic.
// Evaluates the execute-stage condition field against the stored flags, gates
// register/memory writes and PC redirects, updates the flags from the ALU, and
// squashes younger instructions for FLUSH_CYCLES cycles after a taken redirect.
// Optional feature macro: COND_NV_TRAP_EN (cond 4'hF fails and raises undef_q).
module arm_cond_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [3:0]  RESET_FLAGS  = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic [3:0] ex_cond,
    input  logic [1:0] ex_flag_wr,
    input  logic [3:0] alu_flags,
    input  logic       ex_reg_wr,
    input  logic       ex_mem_wr,
    input  logic       ex_pc_src,
    input  logic       stall,
    output logic       cond_ex,
    output logic [3:0] nzcv_q,
    output logic       reg_wr_q,
    output logic       mem_wr_q,
    output logic       pc_src_q,
    output logic       flush,
    output logic       undef_q
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [2:0] flush_cnt;

    // Condition-field decode against the stored flags {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic pass;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c & !z;
            4'h9:    pass = !c | z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z & (n == v);
            4'hD:    pass = z | (n != v);
            4'hE:    pass = 1'b1;
`ifdef COND_NV_TRAP_EN
            default: pass = 1'b0;
`else
            default: pass = 1'b1;
`endif
        endcase
        return pass;
    endfunction

    assign flush   = (flush_cnt != 3'd0);
    // Uses the registered flags only: a flag-setting instruction affects the next one.
    assign cond_ex = ex_valid & !flush & cond_pass(ex_cond, nzcv_q);

    // Flags, gated commit outputs and squash counter; everything freezes on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q    <= RESET_FLAGS;
            reg_wr_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            pc_src_q  <= 1'b0;
            flush_cnt <= 3'd0;
        end else if (!stall) begin
            if (cond_ex && ex_flag_wr[1]) nzcv_q[3:2] <= alu_flags[3:2];
            if (cond_ex && ex_flag_wr[0]) nzcv_q[1:0] <= alu_flags[1:0];
            reg_wr_q <= ex_reg_wr & cond_ex;
            mem_wr_q <= ex_mem_wr & cond_ex;
            pc_src_q <= ex_pc_src & cond_ex;
            // A taken redirect cannot coincide with flush, so load never races decrement.
            if (ex_pc_src && cond_ex)   flush_cnt <= FLUSH_LOAD;
            else if (flush_cnt != 3'd0) flush_cnt <= flush_cnt - 3'd1;
        end
    end

`ifdef COND_NV_TRAP_EN
    // One-cycle trap pulse for a live NV-condition instruction; never held by stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) undef_q <= 1'b0;
        else        undef_q <= !stall & ex_valid & !flush & (ex_cond == 4'hF);
    end
`else
    assign undef_q = 1'b0;
`endif

endmodule

// File: tb/tb_arm_cond_unit.sv
// Testbench for arm_cond_unit: condition table vectors, hand-written pipeline
// sequences (flag update, branch squash, stall, NV, async reset) and a random
// run against a behavioural model.
module tb_arm_cond_unit;
    localparam int unsigned FC = 2;
    localparam logic [3:0]  RF = 4'b0100;
`ifdef COND_NV_TRAP_EN
    localparam bit NV_TRAP = 1'b1;
`else
    localparam bit NV_TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic [3:0] ex_cond;
    logic [1:0] ex_flag_wr;
    logic [3:0] alu_flags;
    logic       ex_reg_wr, ex_mem_wr, ex_pc_src, stall;
    logic       cond_ex;
    logic [3:0] nzcv_q;
    logic       reg_wr_q, mem_wr_q, pc_src_q, flush, undef_q;

    int checks = 0;
    int errors = 0;

    arm_cond_unit #(.FLUSH_CYCLES(FC), .RESET_FLAGS(RF)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_cond(ex_cond),
        .ex_flag_wr(ex_flag_wr), .alu_flags(alu_flags), .ex_reg_wr(ex_reg_wr),
        .ex_mem_wr(ex_mem_wr), .ex_pc_src(ex_pc_src), .stall(stall),
        .cond_ex(cond_ex), .nzcv_q(nzcv_q), .reg_wr_q(reg_wr_q), .mem_wr_q(mem_wr_q),
        .pc_src_q(pc_src_q), .flush(flush), .undef_q(undef_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nzcv;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] cond, input logic [1:0] fw,
                         input logic [3:0] alu, input logic rw, input logic mw,
                         input logic pc, input logic st);
        ex_valid = v; ex_cond = cond; ex_flag_wr = fw; alu_flags = alu;
        ex_reg_wr = rw; ex_mem_wr = mw; ex_pc_src = pc; stall = st;
    endtask

    // ARM structure: even codes name a predicate, odd codes invert it; 0xF is special.
    function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (cond == 4'hF) return !NV_TRAP;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    // Behavioural model state
    logic [3:0] m_nzcv;
    int         m_cnt;
    logic       m_reg, m_mem, m_pc, m_undef;

    initial begin
        logic       v, rw, mw, pc, st, ce;
        logic [3:0] cond, alu;
        logic [1:0] fw;

        vecs.push_back('{4'b0100, 4'h0, 1'b1});
        vecs.push_back('{4'b0100, 4'h1, 1'b0});
        vecs.push_back('{4'b0100, 4'h8, 1'b0});
        vecs.push_back('{4'b0100, 4'h9, 1'b1});
        vecs.push_back('{4'b0010, 4'h2, 1'b1});
        vecs.push_back('{4'b0010, 4'h3, 1'b0});
        vecs.push_back('{4'b0010, 4'h8, 1'b1});
        vecs.push_back('{4'b0010, 4'h9, 1'b0});
        vecs.push_back('{4'b0010, 4'h0, 1'b0});
        vecs.push_back('{4'b1000, 4'h4, 1'b1});
        vecs.push_back('{4'b1000, 4'h5, 1'b0});
        vecs.push_back('{4'b1000, 4'hA, 1'b0});
        vecs.push_back('{4'b1000, 4'hB, 1'b1});
        vecs.push_back('{4'b1000, 4'hD, 1'b1});
        vecs.push_back('{4'b1000, 4'hC, 1'b0});
        vecs.push_back('{4'b0001, 4'h6, 1'b1});
        vecs.push_back('{4'b0001, 4'h7, 1'b0});
        vecs.push_back('{4'b0001, 4'hA, 1'b0});
        vecs.push_back('{4'b1001, 4'hA, 1'b1});
        vecs.push_back('{4'b1001, 4'hB, 1'b0});
        vecs.push_back('{4'b1001, 4'hC, 1'b1});
        vecs.push_back('{4'b1001, 4'hD, 1'b0});
        vecs.push_back('{4'b0000, 4'hE, 1'b1});
        vecs.push_back('{4'b0000, 4'hC, 1'b1});
        vecs.push_back('{4'b0000, 4'h5, 1'b1});
        vecs.push_back('{4'b0000, 4'h7, 1'b1});
        vecs.push_back('{4'b1101, 4'hC, 1'b0});
        vecs.push_back('{4'b1101, 4'hD, 1'b1});
        vecs.push_back('{4'b0000, 4'hF, !NV_TRAP});

        rst_n = 1'b0;
        drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst nzcv", nzcv_q, RF);
        chk("rst reg_wr_q", reg_wr_q, 0);
        chk("rst mem_wr_q", mem_wr_q, 0);
        chk("rst pc_src_q", pc_src_q, 0);
        chk("rst undef_q", undef_q, 0);
        chk("rst flush", flush, 0);
        drive(1, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);
        #1 chk("rst EQ cond_ex", cond_ex, 1);

        // SUBS-like flag update, then NE sees new Z
        @(negedge clk);
        drive(1, 4'hE, 2'b11, 4'b0110, 0, 0, 0, 0);
        @(negedge clk);
        chk("subs nzcv", nzcv_q, 4'b0110);
        drive(1, 4'h1, 2'b00, 4'h0, 1, 0, 0, 0);
        #1 chk("subs NE cond_ex", cond_ex, 0);
        @(negedge clk);
        chk("subs reg_wr_q", reg_wr_q, 0);

        // Taken branch, then stall during count 2
        drive(1, 4'hE, 2'b00, 4'h0, 0, 0, 1, 0);
        #1 chk("br cond_ex", cond_ex, 1);
        @(negedge clk);
        chk("br pc_src_q", pc_src_q, 1);
        chk("br flush", flush, 1);
        drive(1, 4'hE, 2'b11, 4'b1111, 0, 1, 0, 1);
        #1 chk("stall squashed cond_ex", cond_ex, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall flush", flush, 1);
            chk("stall nzcv", nzcv_q, 4'b0110);
            chk("stall pc_src_q", pc_src_q, 1);
        end
        drive(1, 4'hE, 2'b00, 4'h0, 0, 1, 0, 0);
        #1 chk("flush AL cond_ex", cond_ex, 0);
        @(negedge clk);
        chk("flush mem_wr_q", mem_wr_q, 0);
        chk("flush cnt1", flush, 1);
        chk("flush pc_src_q clr", pc_src_q, 0);
        drive(0, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush done", flush, 0);

        // NV condition
        drive(1, 4'hF, 2'b00, 4'h0, 0, 0, 0, 0);
        #1 chk("nv cond_ex", cond_ex, !NV_TRAP);
        @(negedge clk);
        chk("nv undef pulse", undef_q, NV_TRAP);
        drive(1, 4'hE, 2'b00, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("nv undef end", undef_q, 0);

        // Async reset mid-flush
        drive(1, 4'hE, 2'b00, 4'h0, 0, 0, 1, 0);
        @(negedge clk);
        chk("arst pre flush", flush, 1);
        drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst flush", flush, 0);
        chk("arst pc_src_q", pc_src_q, 0);
        chk("arst nzcv", nzcv_q, RF);
        @(negedge clk);
        rst_n = 1'b1;

        // Condition table
        foreach (vecs[i]) begin
            drive(1, 4'hE, 2'b11, vecs[i].nzcv, 0, 0, 0, 0);
            @(negedge clk);
            chk("tbl nzcv", nzcv_q, vecs[i].nzcv);
            drive(1, vecs[i].cond, 2'b00, 4'h0, 0, 0, 0, 0);
            #1 chk($sformatf("tbl cond %0h nzcv %b", vecs[i].cond, vecs[i].nzcv),
                   cond_ex, vecs[i].exp);
            @(negedge clk);
        end

        // Random run against the model
        drive(0, 4'h0, 2'b00, 4'h0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        m_nzcv = RF; m_cnt = 0; m_reg = 0; m_mem = 0; m_pc = 0; m_undef = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            chk("rnd nzcv", nzcv_q, m_nzcv);
            chk("rnd reg_wr_q", reg_wr_q, m_reg);
            chk("rnd mem_wr_q", mem_wr_q, m_mem);
            chk("rnd pc_src_q", pc_src_q, m_pc);
            chk("rnd flush", flush, m_cnt != 0);
            chk("rnd undef_q", undef_q, m_undef);
            v    = ($urandom_range(0, 3) != 0);
            cond = 4'($urandom);
            fw   = 2'($urandom);
            alu  = 4'($urandom);
            rw   = 1'($urandom);
            mw   = 1'($urandom);
            pc   = ($urandom_range(0, 5) == 0);
            st   = ($urandom_range(0, 4) == 0);
            drive(v, cond, fw, alu, rw, mw, pc, st);
            #1;
            ce = v && (m_cnt == 0) && ref_pass(cond, m_nzcv);
            chk("rnd cond_ex", cond_ex, ce);
            if (!st) begin
                m_undef = NV_TRAP && v && (m_cnt == 0) && (cond == 4'hF);
                if (ce && fw[1]) begin m_nzcv[3] = alu[3]; m_nzcv[2] = alu[2]; end
                if (ce && fw[0]) begin m_nzcv[1] = alu[1]; m_nzcv[0] = alu[0]; end
                m_reg = rw && ce;
                m_mem = mw && ce;
                m_pc  = pc && ce;
                if (pc && ce)       m_cnt = FC;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else begin
                m_undef = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
